// File: rtl/fmac_rx_port_arb.sv
// Per-packet round-robin arbiter: moves one whole packet from one of two FMAC RX ports into
// the shared host data FIFO, then writes a count word {bcnt, err, port}.
module fmac_rx_port_arb #(
  parameter int          DATA_WIDTH = 64,
  parameter int          BCNT_WIDTH = 32,
  parameter int          RD_LAT     = 1,
  parameter logic [15:0] MAX_BCNT   = 16'd9600
) (
  input  logic                  clk_fib,
  input  logic                  reset_,
  input  logic [1:0]            fib_rx_mac_data_empty,
  input  logic [1:0]            fib_rx_mac_ipcs_empty,
  input  logic [DATA_WIDTH-1:0] fib_rx_mac_pkt_data0,
  input  logic [DATA_WIDTH-1:0] fib_rx_mac_pkt_data1,
  input  logic [63:0]           fib_rx_mac_ipcs_data0,
  input  logic [63:0]           fib_rx_mac_ipcs_data1,
  output logic [1:0]            fib_rx_mac_rd,
  output logic [1:0]            fib_rx_mac_ipcs_rd,
  input  logic                  rf_afull,
  input  logic                  rcf_full,
  output logic                  wren_rf,
  output logic [DATA_WIDTH-1:0] datain_rf,
  output logic                  wren_rcf,
  output logic [BCNT_WIDTH-1:0] datain_rcf,
  output logic                  grant_port,
  output logic [4:0]            arb_state
);

  localparam logic [4:0] S_IDLE   = 5'b00001;
  localparam logic [4:0] S_GRANT  = 5'b00010;
  localparam logic [4:0] S_LDCNT  = 5'b00100;
  localparam logic [4:0] S_RDDATA = 5'b01000;
  localparam logic [4:0] S_DRAIN  = 5'b10000;

  // RD_LAT is 1..3, so a 2-bit wait counter always suffices.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  logic [4:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic [1:0]            lat_q, lat_d;
  logic [15:0]           bcnt_q, bcnt_d;
  logic                  err_q, err_d;
  logic [13:0]           words_left_q, words_left_d;
  logic [RD_LAT:0]       rd_pipe_q;
  logic [DATA_WIDTH-1:0] datain_rf_q;
  logic                  wren_rcf_q, wren_rcf_d;
  logic [BCNT_WIDTH-1:0] datain_rcf_q, datain_rcf_d;

  logic [1:0]            req;
  logic [1:0]            port_sel;
  logic [15:0]           ipcs_bcnt;
  logic [16:0]           bcnt_rnd;
  logic [13:0]           words_new;
  logic                  data_empty_g;
  logic                  rd_g;
  logic                  in_flight;
  logic                  unused_ipcs;

  assign req          = ~fib_rx_mac_ipcs_empty & ~fib_rx_mac_data_empty;
  assign port_sel     = grant_q ? 2'b10 : 2'b01;
  assign ipcs_bcnt    = grant_q ? fib_rx_mac_ipcs_data1[63:48] : fib_rx_mac_ipcs_data0[63:48];
  assign unused_ipcs  = ^{fib_rx_mac_ipcs_data0[47:0], fib_rx_mac_ipcs_data1[47:0]};

  // 14-bit word count so that even bcnt=16'hFFFF rounds up without wrapping.
  assign bcnt_rnd     = {1'b0, ipcs_bcnt} + 17'd7;
  assign words_new    = bcnt_rnd[16:3];

  assign data_empty_g = grant_q ? fib_rx_mac_data_empty[1] : fib_rx_mac_data_empty[0];
  assign rd_g         = (state_q == S_RDDATA) && (words_left_q != 14'd0) && !data_empty_g;
  assign in_flight    = |rd_pipe_q[RD_LAT-1:0];

  assign fib_rx_mac_rd      = rd_g ? port_sel : 2'b00;
  assign fib_rx_mac_ipcs_rd = (state_q == S_GRANT) ? port_sel : 2'b00;
  assign wren_rf            = rd_pipe_q[RD_LAT];
  assign datain_rf          = datain_rf_q;
  assign wren_rcf           = wren_rcf_q;
  assign datain_rcf         = datain_rcf_q;
  assign grant_port         = grant_q;
  // Debug view reads all-zero while reset is held, IDLE otherwise.
  assign arb_state          = state_q & {5{reset_}};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    lat_d        = lat_q;
    bcnt_d       = bcnt_q;
    err_d        = err_q;
    words_left_d = words_left_q;
    wren_rcf_d   = 1'b0;
    datain_rcf_d = datain_rcf_q;

    case (state_q)
      S_IDLE: begin
        if (!rf_afull && !rcf_full && (req != 2'b00)) begin
          state_d = S_GRANT;
          grant_d = (req == 2'b11) ? ~last_grant_q : req[1];
        end
      end
      S_GRANT: begin
        state_d = S_LDCNT;
        lat_d   = 2'd0;
      end
      S_LDCNT: begin
        if (lat_q == LAT_LAST) begin
          bcnt_d       = ipcs_bcnt;
          words_left_d = words_new;
          err_d        = (ipcs_bcnt == 16'd0) || (ipcs_bcnt > MAX_BCNT);
          state_d      = (ipcs_bcnt == 16'd0) ? S_DRAIN : S_RDDATA;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RDDATA: begin
        if (rd_g) begin
          words_left_d = words_left_q - 14'd1;
          if (words_left_q == 14'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once no read is awaiting its data the final data write is already registered,
        // so the count word lands strictly after it.
        if (!in_flight) begin
          wren_rcf_d   = 1'b1;
          datain_rcf_d = {bcnt_q, {(BCNT_WIDTH-18){1'b0}}, err_q, grant_q};
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_fib or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      lat_q        <= 2'd0;
      bcnt_q       <= 16'd0;
      err_q        <= 1'b0;
      words_left_q <= 14'd0;
      rd_pipe_q    <= '0;
      datain_rf_q  <= '0;
      wren_rcf_q   <= 1'b0;
      datain_rcf_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      lat_q        <= lat_d;
      bcnt_q       <= bcnt_d;
      err_q        <= err_d;
      words_left_q <= words_left_d;
      rd_pipe_q    <= {rd_pipe_q[RD_LAT-1:0], rd_g};
      wren_rcf_q   <= wren_rcf_d;
      datain_rcf_q <= datain_rcf_d;
      // Read data is valid RD_LAT cycles after the strobe; capture it then.
      if (rd_pipe_q[RD_LAT-1]) begin
        datain_rf_q <= grant_q ? fib_rx_mac_pkt_data1 : fib_rx_mac_pkt_data0;
      end
    end
  end

endmodule

// File: tb/tb_fmac_rx_port_arb.sv
// Directed bench for fmac_rx_port_arb with two modelled FMAC RX FIFO sets (read latency 1).
module tb_fmac_rx_port_arb;

  logic        clk_fib = 1'b0;
  logic        reset_;
  logic [1:0]  data_empty, ipcs_empty, rd, ipcs_rd;
  logic [63:0] pkt0, pkt1, ipcs0, ipcs1, datain_rf;
  logic        rf_afull, rcf_full, wren_rf, wren_rcf, grant_port;
  logic [31:0] datain_rcf;
  logic [4:0]  arb_state;

  always #4 clk_fib = ~clk_fib;

  fmac_rx_port_arb #(.DATA_WIDTH(64), .BCNT_WIDTH(32), .RD_LAT(1), .MAX_BCNT(16'd9600)) dut (
    .clk_fib(clk_fib), .reset_(reset_),
    .fib_rx_mac_data_empty(data_empty), .fib_rx_mac_ipcs_empty(ipcs_empty),
    .fib_rx_mac_pkt_data0(pkt0), .fib_rx_mac_pkt_data1(pkt1),
    .fib_rx_mac_ipcs_data0(ipcs0), .fib_rx_mac_ipcs_data1(ipcs1),
    .fib_rx_mac_rd(rd), .fib_rx_mac_ipcs_rd(ipcs_rd),
    .rf_afull(rf_afull), .rcf_full(rcf_full),
    .wren_rf(wren_rf), .datain_rf(datain_rf),
    .wren_rcf(wren_rcf), .datain_rcf(datain_rcf),
    .grant_port(grant_port), .arb_state(arb_state)
  );

  // FIFO model: push side owned by the stimulus, pop side by the model process.
  int          d_push[2] = '{0, 0};
  int          i_push[2] = '{0, 0};
  int          d_pop[2]  = '{0, 0};
  int          i_pop[2]  = '{0, 0};
  logic [15:0] ipcs_mem [2][0:63];
  logic [63:0] exp_mem [0:4095];
  int          exp_wr = 0;
  logic [1:0]  rd_s = 2'b00, ird_s = 2'b00;

  assign data_empty[0] = (d_push[0] == d_pop[0]);
  assign data_empty[1] = (d_push[1] == d_pop[1]);
  assign ipcs_empty[0] = (i_push[0] == i_pop[0]);
  assign ipcs_empty[1] = (i_push[1] == i_pop[1]);

  function automatic logic [63:0] word_of(input int p, input int k);
    return {8'hD0 + 8'(p), 24'h0, 32'(k)};
  endfunction

  always @(negedge clk_fib) begin
    rd_s  <= rd;
    ird_s <= ipcs_rd;
  end

  always @(posedge clk_fib) begin
    if (rd_s[0]) begin
      pkt0 <= word_of(0, d_pop[0]);
      exp_mem[exp_wr[11:0]] <= word_of(0, d_pop[0]);
      d_pop[0] <= d_pop[0] + 1;
      exp_wr <= exp_wr + 1;
    end else if (rd_s[1]) begin
      pkt1 <= word_of(1, d_pop[1]);
      exp_mem[exp_wr[11:0]] <= word_of(1, d_pop[1]);
      d_pop[1] <= d_pop[1] + 1;
      exp_wr <= exp_wr + 1;
    end
    if (ird_s[0]) begin
      ipcs0 <= {ipcs_mem[0][i_pop[0][5:0]], 48'h0};
      i_pop[0] <= i_pop[0] + 1;
    end
    if (ird_s[1]) begin
      ipcs1 <= {ipcs_mem[1][i_pop[1][5:0]], 48'h0};
      i_pop[1] <= i_pop[1] + 1;
    end
  end

  // Output monitor: logs count words, grants and per-packet write statistics.
  int          cyc = 0, nwr = 0, nrd = 0, nrcf = 0, ngnt = 0;
  int          data_err = 0, ovl_err = 0, under_err = 0;
  int          pkt_wr = 0, first_wr = 0, last_wr = 0, exp_rd = 0;
  logic [31:0] rcf_log [0:63];
  int          wlog [0:63];
  int          span_log [0:63];
  logic        gnt_log [0:63];

  always @(negedge clk_fib) begin
    cyc <= cyc + 1;
    if (!reset_) begin
      exp_rd <= exp_wr;
      pkt_wr <= 0;
    end else begin
      if (rd != 2'b00) nrd <= nrd + 1;
      if ((rd & data_empty) != 2'b00) under_err <= under_err + 1;
      if ((rd[0] | ipcs_rd[0]) && (rd[1] | ipcs_rd[1])) ovl_err <= ovl_err + 1;
      if (ipcs_rd != 2'b00) begin
        gnt_log[ngnt[5:0]] <= ipcs_rd[1];
        ngnt <= ngnt + 1;
      end
      if (wren_rf) begin
        if (exp_rd == exp_wr || datain_rf !== exp_mem[exp_rd[11:0]]) data_err <= data_err + 1;
        exp_rd <= exp_rd + 1;
        nwr    <= nwr + 1;
        if (pkt_wr == 0) first_wr <= cyc;
        last_wr <= cyc;
        pkt_wr  <= pkt_wr + 1;
      end
      if (wren_rcf) begin
        rcf_log[nrcf[5:0]]  <= datain_rcf;
        wlog[nrcf[5:0]]     <= pkt_wr;
        span_log[nrcf[5:0]] <= (pkt_wr == 0) ? 0 : (last_wr - first_wr + 1);
        pkt_wr <= 0;
        nrcf   <= nrcf + 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_fib);
    #1;
  endtask

  task automatic push_pkt(input int p, input logic [15:0] bcnt, input int nwords);
    ipcs_mem[p][i_push[p][5:0]] = bcnt;
    i_push[p] = i_push[p] + 1;
    d_push[p] = d_push[p] + nwords;
  endtask

  task automatic wait_rcf(input int target, input int budget, input string tag);
    int k = 0;
    while (nrcf < target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(nrcf >= target), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"}, 64'(rd), 64'd0);
    chk({tag, "_ipcs_rd"}, 64'(ipcs_rd), 64'd0);
    chk({tag, "_wren_rf"}, 64'(wren_rf), 64'd0);
    chk({tag, "_datain_rf"}, datain_rf, 64'd0);
    chk({tag, "_wren_rcf"}, 64'(wren_rcf), 64'd0);
    chk({tag, "_datain_rcf"}, 64'(datain_rcf), 64'd0);
    chk({tag, "_grant"}, 64'(grant_port), 64'd0);
    chk({tag, "_state"}, 64'(arb_state), 64'd0);
  endtask

  initial begin
    int base_nrd, base_g, k;
    reset_   = 1'b0;
    rf_afull = 1'b0;
    rcf_full = 1'b0;
    #3;
    chk_all_zero("reset");
    tick(2);
    reset_ = 1'b1;
    tick(5);
    chk("idle_state", 64'(arb_state), 64'h01);
    chk("idle_no_grant", 64'(ngnt), 64'd0);

    // Single 64-byte packet on port 0.
    push_pkt(0, 16'd64, 8);
    wait_rcf(1, 100, "t1_done");
    chk("t1_rcf", 64'(rcf_log[0]), 64'h0040_0000);
    chk("t1_words", 64'(wlog[0]), 64'd8);
    chk("t1_consecutive", 64'(span_log[0]), 64'd8);
    chk("t1_grant", 64'(gnt_log[0]), 64'd0);
    tick(2);
    chk("t1_idle", 64'(arb_state), 64'h01);
    chk("t1_data", 64'(data_err), 64'd0);

    // Both ports pending from reset: strict alternation starting with port 0.
    reset_ = 1'b0;
    tick(1);
    push_pkt(0, 16'd16, 2); push_pkt(0, 16'd24, 3); push_pkt(0, 16'd8, 1);
    push_pkt(1, 16'd40, 5); push_pkt(1, 16'd1, 1);  push_pkt(1, 16'd17, 3);
    reset_ = 1'b1;
    wait_rcf(7, 400, "t2_done");
    chk("t2_rcf1", 64'(rcf_log[1]), 64'h0010_0000);
    chk("t2_rcf2", 64'(rcf_log[2]), 64'h0028_0001);
    chk("t2_rcf3", 64'(rcf_log[3]), 64'h0018_0000);
    chk("t2_rcf4", 64'(rcf_log[4]), 64'h0001_0001);
    chk("t2_rcf5", 64'(rcf_log[5]), 64'h0008_0000);
    chk("t2_rcf6", 64'(rcf_log[6]), 64'h0011_0001);
    chk("t2_order", 64'({gnt_log[1], gnt_log[2], gnt_log[3], gnt_log[4], gnt_log[5], gnt_log[6]}), 64'b010101);
    chk("t2_words", 64'({wlog[1][7:0], wlog[2][7:0], wlog[3][7:0], wlog[4][7:0], wlog[5][7:0], wlog[6][7:0]}),
        64'h02_05_03_01_01_03);
    chk("t2_overlap", 64'(ovl_err), 64'd0);
    chk("t2_data", 64'(data_err), 64'd0);

    // Port 1, 13 bytes, data FIFO runs dry for two cycles after the first word.
    push_pkt(1, 16'd13, 1);
    k = 0;
    while (!rd[1] && k < 50) begin tick(1); k++; end
    chk("t3_first_rd", 64'(rd[1]), 64'd1);
    tick(3);
    d_push[1] = d_push[1] + 1;
    wait_rcf(8, 100, "t3_done");
    chk("t3_rcf", 64'(rcf_log[7]), 64'h000D_0001);
    chk("t3_words", 64'(wlog[7]), 64'd2);
    chk("t3_underflow", 64'(under_err), 64'd0);

    // Zero-length packet, then oversize packet on port 0 (one shared data word left over).
    base_nrd = nrd;
    push_pkt(0, 16'd0, 1);
    wait_rcf(9, 100, "t4a_done");
    chk("t4a_rcf", 64'(rcf_log[8]), 64'h0000_0002);
    chk("t4a_no_rd", 64'(nrd - base_nrd), 64'd0);
    chk("t4a_no_wr", 64'(wlog[8]), 64'd0);
    push_pkt(0, 16'd9601, 1200);
    wait_rcf(10, 2500, "t4b_done");
    chk("t4b_rcf", 64'(rcf_log[9]), 64'h2581_0002);
    chk("t4b_words", 64'(wlog[9]), 64'd1201);
    chk("t4b_data", 64'(data_err), 64'd0);

    // rf_afull blocks arbitration; release grants port 0 next cycle.
    reset_ = 1'b0;
    tick(1);
    push_pkt(0, 16'd8, 1);
    push_pkt(1, 16'd8, 1);
    rf_afull = 1'b1;
    reset_   = 1'b1;
    base_g   = ngnt;
    tick(20);
    chk("t5_no_grant", 64'(ngnt - base_g), 64'd0);
    chk("t5_idle", 64'(arb_state), 64'h01);
    rf_afull = 1'b0;
    tick(1);
    chk("t5_ipcs_rd", 64'(ipcs_rd), 64'b01);
    wait_rcf(12, 100, "t5_done");
    chk("t5_rcf0", 64'(rcf_log[10]), 64'h0008_0000);
    chk("t5_rcf1", 64'(rcf_log[11]), 64'h0008_0001);

    // Async reset during the third data read of a 64-byte packet.
    push_pkt(0, 16'd64, 8);
    base_nrd = nrd;
    k = 0;
    while (!(nrd == base_nrd + 2 && rd[0]) && k < 60) begin tick(1); k++; end
    chk("t6_reached_word3", 64'(nrd - base_nrd), 64'd2);
    reset_ = 1'b0;
    #1;
    chk_all_zero("t6_async");
    tick(3);
    chk("t6_no_rcf", 64'(nrcf), 64'd12);
    push_pkt(0, 16'd48, 0);
    push_pkt(1, 16'd8, 1);
    base_g = ngnt;
    reset_ = 1'b1;
    wait_rcf(14, 200, "t6_done");
    chk("t6_first_grant", 64'(gnt_log[base_g[5:0]]), 64'd0);
    chk("t6_rcf0", 64'(rcf_log[12]), 64'h0030_0000);
    chk("t6_rcf1", 64'(rcf_log[13]), 64'h0008_0001);
    chk("t6_words", 64'(wlog[12]), 64'd6);
    chk("final_data", 64'(data_err), 64'd0);
    chk("final_overlap", 64'(ovl_err), 64'd0);
    chk("final_underflow", 64'(under_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
